// File: rtl/fft_pkt_pkg.sv
// Shared constants, FIFO entry layout and write-FSM states for the FFT sink
// packetizer.
package fft_pkt_pkg;
  localparam int DW = 18;
  localparam int PW = 11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } wr_state_t;

  // One buffered sample plus the framing tag it was written with
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic                 sop;
    logic                 eop;
    logic [PW-1:0]        pts;
    logic                 inv;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  function automatic logic is_pow2(input logic [PW-1:0] v);
    return (v != '0) && ((v & (v - PW'(1))) == '0);
  endfunction
endpackage

// File: rtl/fft_frame_packetizer_if.sv
// Avalon-ST sink-side bus towards the FFT core, with per-packet fftpts/inverse
// sideband aligned to the sop beat.
interface fft_frame_packetizer_if;
  import fft_pkt_pkg::*;

  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           out_error;
  logic                 out_sop;
  logic                 out_eop;
  logic signed [DW-1:0] out_real;
  logic signed [DW-1:0] out_imag;
  logic [PW-1:0]        out_fftpts;
  logic                 out_inverse;

  modport master (
    output out_valid, out_error, out_sop, out_eop, out_real, out_imag,
           out_fftpts, out_inverse,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_error, out_sop, out_eop, out_real, out_imag,
           out_fftpts, out_inverse,
    output out_ready
  );
endinterface

// File: rtl/fft_frame_packetizer_sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data always presents the head entry, so a
// read and the consumer's load happen in the same cycle.
module fft_frame_packetizer_sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic         do_wr;
  logic         do_rd;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A read in the same cycle frees the slot, so a write on full still lands
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_reg[AW-1:0]];
endmodule

// File: rtl/fft_frame_packetizer.sv
// Frames an unthrottled sample stream into fftpts-long Avalon-ST packets and
// feeds the FFT sink through a FIFO and one output register stage.
module fft_frame_packetizer
  import fft_pkt_pkg::*;
#(
  parameter int FIFO_AW = 11,
  parameter int MIN_PTS = 64,
  parameter int MAX_PTS = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_imag,
  input  logic [PW-1:0]        fftpts_cfg,
  input  logic                 inverse_cfg,
  fft_frame_packetizer_if.master sink,
  output logic                 ovf_flag,
  input  logic                 ovf_clr,
  output logic [15:0]          frame_cnt
);
  wr_state_t     state_reg, state_next;
  logic [PW-1:0] wr_cnt_reg, wr_cnt_next;
  logic [PW-1:0] pts_reg, pts_next;
  logic          inv_reg, inv_next;
  logic          wr_beat, wr_sop, wr_eop, cfg_legal;
  fifo_entry_t   wr_entry, rd_entry;
  logic          fifo_full, fifo_empty, fifo_rd, load, drop;

  assign cfg_legal = is_pow2(fftpts_cfg) &&
                     (fftpts_cfg >= PW'(MIN_PTS)) && (fftpts_cfg <= PW'(MAX_PTS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      wr_cnt_reg <= '0;
      pts_reg    <= PW'(MAX_PTS);
      inv_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_cnt_reg <= wr_cnt_next;
      pts_reg    <= pts_next;
      inv_reg    <= inv_next;
    end
  end

  // wr_cnt is 0 only at a frame boundary, so it alone marks the sop beat
  always_comb begin
    state_next  = state_reg;
    wr_cnt_next = wr_cnt_reg;
    pts_next    = pts_reg;
    inv_next    = inv_reg;
    wr_beat     = in_valid && ((state_reg == RUN) || enable);
    wr_sop      = wr_beat && (wr_cnt_reg == '0);
    if (wr_sop) begin
      if (cfg_legal) pts_next = fftpts_cfg;
      inv_next = inverse_cfg;
    end
    wr_eop = wr_beat && (wr_cnt_reg == pts_next - PW'(1));
    if (wr_beat) begin
      state_next  = RUN;
      wr_cnt_next = wr_cnt_reg + PW'(1);
      if (wr_eop) begin
        wr_cnt_next = '0;
        if (!enable) state_next = IDLE;
      end
    end
  end

  assign wr_entry = '{re: in_real, im: in_imag, sop: wr_sop, eop: wr_eop,
                      pts: pts_next, inv: inv_next};

  assign load    = !sink.out_valid || sink.out_ready;
  assign fifo_rd = load && !fifo_empty;
  // The write counter still advances on a drop so the frame length stays exact
  assign drop    = wr_beat && fifo_full && !fifo_rd;

  fft_frame_packetizer_sync_fifo #(
    .W  (ENTRY_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_beat),
    .wr_data (wr_entry),
    .rd_en   (fifo_rd),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign sink.out_error = 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      sink.out_valid   <= 1'b0;
      sink.out_sop     <= 1'b0;
      sink.out_eop     <= 1'b0;
      sink.out_real    <= '0;
      sink.out_imag    <= '0;
      sink.out_fftpts  <= PW'(MAX_PTS);
      sink.out_inverse <= 1'b0;
      frame_cnt        <= '0;
      ovf_flag         <= 1'b0;
    end else begin
      if (load) begin
        sink.out_valid <= !fifo_empty;
        if (!fifo_empty) begin
          sink.out_real <= rd_entry.re;
          sink.out_imag <= rd_entry.im;
          sink.out_sop  <= rd_entry.sop;
          sink.out_eop  <= rd_entry.eop;
          if (rd_entry.sop) begin
            sink.out_fftpts  <= rd_entry.pts;
            sink.out_inverse <= rd_entry.inv;
          end
        end
      end
      if (sink.out_valid && sink.out_ready && sink.out_eop)
        frame_cnt <= frame_cnt + 16'd1;
      if (drop)
        ovf_flag <= 1'b1;
      else if (ovf_clr)
        ovf_flag <= 1'b0;
    end
  end
endmodule
